// File: rtl/sram_bus_ctrl.sv
// Three-cycle access controller for a 256Kx16 asynchronous SRAM.
// All SRAM strobes and the bus-drive enable are registered from next-state logic.
module sram_bus_ctrl #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_f2s,
  output logic              ready,
  output logic [DATA_W-1:0] data_s2f_r,
  output logic [DATA_W-1:0] data_s2f_ur,
  output logic [ADDR_W-1:0] ad,
  output logic              we_n,
  output logic              oe_n,
  inout  wire  [DATA_W-1:0] dio_a,
  output logic              ce_a_n,
  output logic              ub_a_n,
  output logic              lb_a_n
);

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    WR1,
    WR2
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              we_n_reg, we_n_next;
  logic              oe_n_reg, oe_n_next;
  logic              tri_reg, tri_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      we_n_reg  <= 1'b1;
      oe_n_reg  <= 1'b1;
      tri_reg   <= 1'b0;
    end else begin
      state     <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      we_n_reg  <= we_n_next;
      oe_n_reg  <= oe_n_next;
      tri_reg   <= tri_next;
    end
  end

  // Strobes are decoded from the next state so they change in step with it.
  always_comb begin
    state_next = state;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    case (state)
      IDLE: begin
        if (mem) begin
          addr_next = addr;
          if (rw) begin
            state_next = RD1;
          end else begin
            wdata_next = data_f2s;
            state_next = WR1;
          end
        end
      end
      RD1: state_next = RD2;
      RD2: begin
        rdata_next = dio_a;
        state_next = IDLE;
      end
      WR1: state_next = WR2;
      WR2: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    we_n_next = (state_next != WR1);
    oe_n_next = !((state_next == RD1) || (state_next == RD2));
    tri_next  = (state_next == WR1) || (state_next == WR2);
  end

  assign dio_a       = tri_reg ? wdata_reg : {DATA_W{1'bz}};
  assign data_s2f_ur = dio_a;
  assign data_s2f_r  = rdata_reg;
  assign ad          = addr_reg;
  assign we_n        = we_n_reg;
  assign oe_n        = oe_n_reg;
  assign ready       = (state == IDLE);
  assign ce_a_n      = 1'b0;
  assign ub_a_n      = 1'b0;
  assign lb_a_n      = 1'b0;

  // Bus-contention guards: never read and write at once, never drive while SRAM outputs.
  assert property (@(posedge clk) disable iff (!reset) !(!we_n_reg && !oe_n_reg));
  assert property (@(posedge clk) disable iff (!reset) !(tri_reg && !oe_n_reg));

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Scoreboard bench for sram_bus_ctrl with a behavioural async SRAM on dio_a.
// Stimulus pushes expected accesses; a negedge monitor pops and compares them.
module tb_sram_bus_ctrl;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_f2s;
  logic              ready;
  logic [DATA_W-1:0] data_s2f_r;
  logic [DATA_W-1:0] data_s2f_ur;
  logic [ADDR_W-1:0] ad;
  logic              we_n;
  logic              oe_n;
  wire  [DATA_W-1:0] dio_a;
  logic              ce_a_n;
  logic              ub_a_n;
  logic              lb_a_n;

  typedef struct {
    bit                is_read;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int issue_cyc   = 0;
  int prev_issue  = 0;
  bit mon_en      = 1'b0;

  logic [DATA_W-1:0] sram    [0:(1<<ADDR_W)-1];
  bit                wr_flag [0:(1<<ADDR_W)-1];

  sram_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .mem(mem), .rw(rw), .addr(addr),
    .data_f2s(data_f2s), .ready(ready), .data_s2f_r(data_s2f_r),
    .data_s2f_ur(data_s2f_ur), .ad(ad), .we_n(we_n), .oe_n(oe_n),
    .dio_a(dio_a), .ce_a_n(ce_a_n), .ub_a_n(ub_a_n), .lb_a_n(lb_a_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Power-up contents of words never written.
  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'h5A5A ^ {14'b0, a[17:16]};
  endfunction

  // SRAM model: word latched while we_n is low, output driven while oe_n is low.
  always @(posedge clk) begin
    if (!we_n) begin
      sram[ad]    = dio_a;
      wr_flag[ad] = 1'b1;
    end
  end

  assign dio_a = (!oe_n) ? (wr_flag[ad] ? sram[ad] : init_word(ad)) : {DATA_W{1'bz}};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit is_read, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input bit hold);
    exp_t e;
    int n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ready_timeout: got ready=0, expected ready=1 within 20 cycles");
    end
    mem      = 1'b1;
    rw       = is_read;
    addr     = a;
    data_f2s = d;
    prev_issue = issue_cyc;
    issue_cyc  = cyc;
    e.is_read = is_read;
    e.addr    = a;
    e.data    = d;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) mem = 1'b0;
  endtask

  // Monitor: writes are checked in C1/C2, reads when oe_n releases in C3.
  int                we_cnt = 0;
  int                oe_cnt = 0;
  logic [DATA_W-1:0] last_wd = '0;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (!we_n) begin
        we_cnt++;
        if (we_cnt == 1) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL sb_underflow: got write at ad=%h, expected no access", ad);
          end else begin
            e = sb.pop_front();
            checkOutput("wr_kind", {31'b0, e.is_read}, 32'd0);
            checkOutput("wr_ad", {14'b0, ad}, {14'b0, e.addr});
            checkOutput("wr_dio_c1", {16'b0, dio_a}, {16'b0, e.data});
            checkOutput("wr_oe_n", {31'b0, oe_n}, 32'd1);
            last_wd = e.data;
          end
        end
      end else if (we_cnt > 0) begin
        checkOutput("we_pulse_width", we_cnt, 1);
        if (!ready) checkOutput("wr_dio_c2", {16'b0, dio_a}, {16'b0, last_wd});
        we_cnt = 0;
      end

      if (!oe_n) begin
        oe_cnt++;
      end else if (oe_cnt > 0) begin
        checkOutput("oe_pulse_width", oe_cnt, 2);
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL sb_underflow: got read at ad=%h, expected no access", ad);
        end else begin
          e = sb.pop_front();
          checkOutput("rd_kind", {31'b0, e.is_read}, 32'd1);
          checkOutput("rd_ad", {14'b0, ad}, {14'b0, e.addr});
          checkOutput("rd_data", {16'b0, data_s2f_r}, {16'b0, e.data});
          checkOutput("rd_ready_c3", {31'b0, ready}, 32'd1);
        end
        oe_cnt = 0;
      end
    end
  end

  initial begin
    reset    = 1'b0;
    mem      = 1'b1;
    rw       = 1'b1;
    addr     = 18'h00005;
    data_f2s = 16'h0000;

    // Reset held two edges with a pending request.
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {31'b0, ready}, 32'd1);
    checkOutput("rst_we_n", {31'b0, we_n}, 32'd1);
    checkOutput("rst_oe_n", {31'b0, oe_n}, 32'd1);
    checkOutput("rst_ad", {14'b0, ad}, 32'd0);
    checkOutput("rst_data_s2f_r", {16'b0, data_s2f_r}, 32'd0);
    checkOutput("rst_tied_enables", {29'b0, ce_a_n, ub_a_n, lb_a_n}, 32'd0);
    reset  = 1'b1;
    mem    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Write then read.
    applyStimulus(1'b0, 18'h00005, 16'h00A5, 1'b0);
    applyStimulus(1'b1, 18'h00005, 16'h00A5, 1'b0);

    // Address boundaries.
    applyStimulus(1'b0, 18'h3FFFF, 16'hC3C3, 1'b0);
    applyStimulus(1'b0, 18'h00000, 16'h3C3C, 1'b0);
    applyStimulus(1'b1, 18'h3FFFF, 16'hC3C3, 1'b0);
    applyStimulus(1'b1, 18'h00000, 16'h3C3C, 1'b0);

    // Write request raised during C1 of a read must be dropped.
    applyStimulus(1'b1, 18'h3FFFF, 16'hC3C3, 1'b1);
    rw       = 1'b0;
    data_f2s = 16'hFFFF;
    @(negedge clk);
    mem = 1'b0;
    applyStimulus(1'b1, 18'h3FFFF, 16'hC3C3, 1'b0);

    // Back-to-back with mem held high.
    for (int k = 0; k < 4; k++) begin
      applyStimulus((k % 2) == 1, 18'h00010, 16'h1234, 1'b1);
      if (k > 0) checkOutput("b2b_spacing", issue_cyc - prev_issue, 3);
    end
    mem = 1'b0;

    // Reset during C1 of a write.
    applyStimulus(1'b0, 18'h00100, 16'hBEEF, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rstwr_we_n", {31'b0, we_n}, 32'd1);
    checkOutput("rstwr_ready", {31'b0, ready}, 32'd1);
    checkOutput("rstwr_oe_n", {31'b0, oe_n}, 32'd1);
    checkOutput("rstwr_bus_released", {31'b0, (dio_a !== 16'hBEEF)}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 18'h00200, init_word(18'h00200), 1'b0);
    applyStimulus(1'b1, 18'h00005, 16'h00A5, 1'b0);

    repeat (6) @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish by 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/sram_bus_ctrl.md
# sram_bus_ctrl

Synchronous controller that turns single-cycle `mem`/`rw` requests from FPGA user logic into timed accesses on the 256K×16 asynchronous SRAM (chip A). It sits between test or application logic and the SRAM pins. It owns the bidirectional data bus and all SRAM control strobes. Each access takes three clock cycles, and `ready` marks when a new request may be accepted.

## Interface
Parameters:
- ADDR_W, 18, SRAM address width
- DATA_W, 16, SRAM data width

Ports:
- clk  in  1  system clock (50 MHz nominal); all logic on rising edge
- reset  in  1  synchronous, active-low reset
- mem  in  1  request strobe; sampled only while ready=1
- rw  in  1  request type: 1 = read, 0 = write
- addr  in  ADDR_W  request address; sampled with mem
- data_f2s  in  DATA_W  write data (FPGA to SRAM); sampled with mem
- ready  out  1  controller idle and able to accept a request
- data_s2f_r  out  DATA_W  registered read data; holds its value until the next read completes
- data_s2f_ur  out  DATA_W  unregistered read data, direct from dio_a
- ad  out  ADDR_W  SRAM address pins (registered)
- we_n  out  1  SRAM write enable, active-low (registered)
- oe_n  out  1  SRAM output enable, active-low (registered)
- dio_a  inout  DATA_W  SRAM data bus; driven only during write states, otherwise Z
- ce_a_n  out  1  chip enable, tied 0
- ub_a_n  out  1  upper byte enable, tied 0
- lb_a_n  out  1  lower byte enable, tied 0

## Operation
- States: IDLE, RD1, RD2, WR1, WR2.
- ready = (state == IDLE).
- IDLE:
  - mem=0: stay in IDLE.
  - mem=1, rw=1: capture addr, go to RD1.
  - mem=1, rw=0: capture addr and data_f2s, go to WR1.
- RD1 → RD2 → IDLE, unconditionally. oe_n=0 throughout RD1 and RD2. On the RD2→IDLE edge, data_s2f_r <= dio_a.
- WR1 → WR2 → IDLE, unconditionally. dio_a is driven with the captured data in both WR1 and WR2. we_n=0 in WR1 only; we_n rises on the WR1→WR2 edge, so data is held for one cycle after the strobe.
- mem, rw, addr and data_f2s are ignored outside IDLE. Requests are not queued; a strobe issued while ready=0 is lost.
- ad, we_n, oe_n and the tristate enable come from registered next-state logic, so the SRAM pins are glitch-free.
- oe_n and we_n are never both 0.
- dio_a is never driven while oe_n=0.
- ad holds the last accessed address while IDLE.

## Timing
- Reset (reset=0 at a rising edge): state=IDLE, ready=1, we_n=1, oe_n=1, dio_a=Z, ad=0, data_s2f_r=0. ce_a_n, ub_a_n and lb_a_n are always 0.
- Reset mid-access: the next edge returns to IDLE with the above values. A truncated write leaves that SRAM word undefined. A truncated read does not update data_s2f_r.
- Cycle numbering: C0 is the cycle in which mem=1 and ready=1 are sampled.
- Read:
  - C1, C2: ad=addr, oe_n=0, ready=0.
  - C3: data_s2f_r valid, ready=1, oe_n=1.
  - Latency: 3 cycles from request to registered data.
- Write:
  - C1: ad=addr, dio_a=data, we_n=0.
  - C2: we_n=1, dio_a still driven.
  - C3: dio_a=Z, ready=1.
- Throughput: one access per 3 cycles. A request held high in C3 starts the next access immediately.
- data_s2f_ur follows dio_a combinationally. It is meaningful only while oe_n=0.
- At 50 MHz, oe_n and we_n assertion widths are 40 ns and 20 ns. Both exceed the 10 ns SRAM tAA and tWP.

## Test plan
- Reset: hold reset=0 for 2 cycles with mem=1 → ready=1, we_n=1, oe_n=1, dio_a=Z, data_s2f_r=0, no state change.
- Write then read: write addr=0x00005, data=0x00A5; then read addr=0x00005 against an SRAM model → we_n low exactly 1 cycle, dio_a=0x00A5 in C1–C2, data_s2f_r=0x00A5 in C3 of the read, oe_n low exactly 2 cycles.
- Ignored request: pulse mem=1, rw=0, data=0xFFFF in C1 of a read to addr 0x3FFFF → no we_n pulse, the read completes normally, and the model is unchanged.
- Back-to-back: mem=1 held continuously, alternating write 0x1234@0x10 and read @0x10 → a new access starts every 3 cycles, read returns 0x1234, and the bus-contention assertion (oe_n=0 while dio_a is driven) never fires.
- Reset mid-write: assert reset=0 in C1 of a write → next cycle we_n=1, dio_a=Z, ready=1; a following read of an untouched address returns the model's prior value.
- Address boundary: write/read at 0x3FFFF and 0x00000 → ad matches exactly, no wrap or truncation, data round-trips.
